// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer driving an external 32x32 multiplier and 64/64 divider.
// Optional per-sub-operation run timeout: define MODEXP_TIMEOUT_EN.
module modexp_ctrl #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   base,
    input  logic [W-1:0]   exp,
    input  logic [W-1:0]   modulus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   result,
    output logic [W-1:0]   mul_ina,
    output logic [W-1:0]   mul_inb,
    output logic           mul_rst_n,
    input  logic [2*W-1:0] mul_result,
    input  logic           mul_ready_n,
    output logic [2*W-1:0] div_a,
    output logic [2*W-1:0] div_b,
    output logic           div_rst_n,
    input  logic [2*W-1:0] div_r,
    input  logic           div_ready_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_NEXT, S_MSETUP, S_MRUN, S_DSETUP, S_DRUN, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_RED, OP_MULT, OP_SQR, OP_FIN
    } op_t;

    state_t         state, state_d;
    op_t            op, op_d;
    logic [W-1:0]   acc, sq, e, m;
    logic [2*W-1:0] prod;
    logic           first;
    logic           mul_hit, div_hit, expired;
    logic [W-1:0]   rem;
    logic           unused_div_hi;

    // The remainder is always below m, so only the low half of div_r matters.
    assign rem           = div_r[W-1:0];
    assign unused_div_hi = ^div_r[2*W-1:W];

    // ready_n is ignored on the first RUN cycle of each launch.
    assign mul_hit = (state == S_MRUN) && !first && !mul_ready_n;
    assign div_hit = (state == S_DRUN) && !first && !div_ready_n;

`ifdef MODEXP_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] run_cnt;

    assign expired = ((state == S_MRUN && !mul_hit) || (state == S_DRUN && !div_hit))
                     && (run_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (state == S_MSETUP || state == S_DSETUP) begin
            run_cnt <= '0;
        end else if (state == S_MRUN || state == S_DRUN) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op     <= OP_RED;
            acc    <= '0;
            sq     <= '0;
            e      <= '0;
            m      <= '0;
            prod   <= '0;
            first  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_d;
            op    <= op_d;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= W'(1);
                        sq     <= base;
                        e      <= exp;
                        m      <= modulus;
                        err    <= (modulus == '0);
                        result <= '0;
                    end
                end
                S_MSETUP, S_DSETUP: first <= 1'b1;
                S_MRUN: begin
                    first <= 1'b0;
                    if (mul_hit) prod <= mul_result;
                end
                S_DRUN: begin
                    first <= 1'b0;
                    if (div_hit) begin
                        case (op)
                            OP_RED:  sq <= rem;
                            OP_MULT: acc <= rem;
                            OP_SQR: begin
                                sq <= rem;
                                e  <= e >> 1;
                            end
                            default: result <= rem;
                        endcase
                    end
                end
                default: ;
            endcase
            if (expired) begin
                err    <= 1'b1;
                result <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state;
        op_d      = op;
        mul_ina   = '0;
        mul_inb   = '0;
        mul_rst_n = 1'b0;
        div_a     = '0;
        div_b     = '0;
        div_rst_n = 1'b0;
        busy      = (state != S_IDLE) && (state != S_DONE);
        done      = (state == S_DONE);

        if (state == S_MSETUP || state == S_MRUN) begin
            mul_ina = (op == OP_MULT) ? acc : sq;
            mul_inb = sq;
        end
        if (state == S_DSETUP || state == S_DRUN) begin
            div_b = {{W{1'b0}}, m};
            case (op)
                OP_RED:  div_a = {{W{1'b0}}, sq};
                OP_FIN:  div_a = {{W{1'b0}}, acc};
                default: div_a = prod;
            endcase
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    op_d    = OP_RED;
                    state_d = (modulus == '0) ? S_DONE : S_DSETUP;
                end
            end
            S_NEXT: begin
                if (e == '0) begin
                    op_d    = OP_FIN;
                    state_d = S_DSETUP;
                end else begin
                    op_d    = e[0] ? OP_MULT : OP_SQR;
                    state_d = S_MSETUP;
                end
            end
            S_MSETUP: state_d = S_MRUN;
            S_MRUN: begin
                mul_rst_n = 1'b1;
                if (mul_hit) state_d = S_DSETUP;
            end
            S_DSETUP: state_d = S_DRUN;
            S_DRUN: begin
                div_rst_n = 1'b1;
                if (div_hit) begin
                    case (op)
                        OP_MULT: begin
                            // MULT leaves e unshifted; the following SQR consumes the bit.
                            if (e[W-1:1] == '0) begin
                                op_d    = OP_FIN;
                                state_d = S_DSETUP;
                            end else begin
                                op_d    = OP_SQR;
                                state_d = S_MSETUP;
                            end
                        end
                        OP_FIN:  state_d = S_DONE;
                        default: state_d = S_NEXT;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (expired) state_d = S_DONE;
    end

endmodule
